// File: rtl/pll_reset_sequencer.sv
// rtl/pll_reset_sequencer.sv - PLL reset pulse, settle wait, heartbeat liveness check and system reset release
module pll_reset_sequencer #(
  parameter int RST_CYCLES    = 16,
  parameter int SETTLE_CYCLES = 2400,
  parameter int HB_TIMEOUT    = 64,
  parameter int HB_GOOD       = 4,
  parameter int MAX_RETRY     = 3
) (
  input  logic       refclk,
  input  logic       reset,
  input  logic       hb_toggle,
  output logic       pll_reset,
  output logic       rst_out,
  output logic       locked,
  output logic       fault,
  output logic [1:0] retry_cnt
);

  localparam int MAX_AB = (RST_CYCLES > SETTLE_CYCLES) ? RST_CYCLES : SETTLE_CYCLES;
  localparam int MAX_CT = (MAX_AB > HB_TIMEOUT) ? MAX_AB : HB_TIMEOUT;
  localparam int CW     = $clog2(MAX_CT) + 1;
  localparam int GW     = $clog2(HB_GOOD) + 1;

  typedef enum logic [2:0] {
    RESET_PLL,
    SETTLE,
    CHECK,
    RUN,
    FAULT
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [CW-1:0] wd;
  logic [GW-1:0] good;
  logic [GW-1:0] good_inc;
  logic          hb_s1, hb_s2, hb_s3;
  logic          hb_edge;
  logic          wd_limit;

  // Two-flop synchronizer for the PLL-domain toggle plus one extra stage for edge detection
  always_ff @(posedge refclk or posedge reset) begin
    if (reset) begin
      hb_s1 <= 1'b0;
      hb_s2 <= 1'b0;
      hb_s3 <= 1'b0;
    end else begin
      hb_s1 <= hb_toggle;
      hb_s2 <= hb_s1;
      hb_s3 <= hb_s2;
    end
  end

  assign hb_edge  = hb_s2 ^ hb_s3;
  assign good_inc = good + GW'(1);
  assign wd_limit = (wd == CW'(HB_TIMEOUT - 1));

  // Sequencer state, counters and output decode registered together on each transition
  always_ff @(posedge refclk or posedge reset) begin
    if (reset) begin
      state     <= RESET_PLL;
      cnt       <= '0;
      wd        <= '0;
      good      <= '0;
      retry_cnt <= 2'd0;
      pll_reset <= 1'b1;
      rst_out   <= 1'b1;
      locked    <= 1'b0;
      fault     <= 1'b0;
    end else begin
      case (state)
        RESET_PLL: begin
          if (cnt == CW'(RST_CYCLES - 1)) begin
            state     <= SETTLE;
            cnt       <= '0;
            pll_reset <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        SETTLE: begin
          if (cnt == CW'(SETTLE_CYCLES - 1)) begin
            state <= CHECK;
            cnt   <= '0;
            wd    <= '0;
            good  <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        CHECK, RUN: begin
          // An edge landing on the threshold cycle wins over the timeout
          if (hb_edge) begin
            wd <= '0;
            if (state == CHECK) begin
              good <= good_inc;
              if (good_inc == GW'(HB_GOOD)) begin
                state   <= RUN;
                rst_out <= 1'b0;
                locked  <= 1'b1;
              end
            end
          end else if (wd_limit) begin
            rst_out <= 1'b1;
            locked  <= 1'b0;
            cnt     <= '0;
            if (retry_cnt < 2'(MAX_RETRY)) begin
              retry_cnt <= retry_cnt + 2'd1;
              state     <= RESET_PLL;
              pll_reset <= 1'b1;
            end else begin
              state     <= FAULT;
              pll_reset <= 1'b1;
              fault     <= 1'b1;
            end
          end else begin
            wd <= wd + 1'b1;
          end
        end
        default: begin
          // FAULT is terminal; any other encoding is forced into it
          state     <= FAULT;
          pll_reset <= 1'b1;
          rst_out   <= 1'b1;
          locked    <= 1'b0;
          fault     <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// tb/tb_pll_reset_sequencer.sv - scenario table plus per-cycle scoreboard for pll_reset_sequencer
module tb_pll_reset_sequencer;

  localparam int R = 4;
  localparam int S = 10;
  localparam int T = 8;
  localparam int G = 3;
  localparam int M = 2;

  localparam int PH_RST = 0;
  localparam int PH_SET = 1;
  localparam int PH_CHK = 2;
  localparam int PH_RUN = 3;
  localparam int PH_FLT = 4;

  logic       refclk = 1'b0;
  logic       reset = 1'b1;
  logic       hb_toggle = 1'b0;
  logic       pll_reset, rst_out, locked, fault;
  logic [1:0] retry_cnt;
  logic [5:0] dut_out;

  int n_total = 0;
  int n_bad = 0;

  logic [5:0] sb_q[$];

  int   m_phase, m_left, m_since, m_good, m_retry;
  logic h1, h2, h3;

  typedef struct {
    string      name;
    int         period;
    int         stop_from;
    int         stop_to;
    int         ncyc;
    int         lock_at;
    logic [5:0] final_out;
  } vec_t;

  vec_t vecs[5];

  pll_reset_sequencer #(
    .RST_CYCLES(R), .SETTLE_CYCLES(S), .HB_TIMEOUT(T), .HB_GOOD(G), .MAX_RETRY(M)
  ) dut (
    .refclk(refclk), .reset(reset), .hb_toggle(hb_toggle),
    .pll_reset(pll_reset), .rst_out(rst_out), .locked(locked),
    .fault(fault), .retry_cnt(retry_cnt)
  );

  assign dut_out = {pll_reset, rst_out, locked, fault, retry_cnt};

  always #5 refclk = ~refclk;

  task automatic check_vec(input string name, input logic [5:0] got, input logic [5:0] want);
    n_total++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s got=%b want=%b", name, got, want);
    end
  endtask

  task automatic check_int(input string name, input int got, input int want);
    n_total++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  task automatic model_reset();
    m_phase = PH_RST;
    m_left  = R;
    m_since = 0;
    m_good  = 0;
    m_retry = 0;
    h1 = 1'b0;
    h2 = 1'b0;
    h3 = 1'b0;
  endtask

  // Advance the reference model by one refclk edge; hb is the value sampled at that edge
  task automatic model_step(input logic hb);
    logic e;
    e  = (h2 != h3);
    h3 = h2;
    h2 = h1;
    h1 = hb;
    case (m_phase)
      PH_RST: begin
        m_left--;
        if (m_left == 0) begin m_phase = PH_SET; m_left = S; end
      end
      PH_SET: begin
        m_left--;
        if (m_left == 0) begin m_phase = PH_CHK; m_since = 0; m_good = 0; end
      end
      PH_CHK, PH_RUN: begin
        if (e) begin
          m_since = 0;
          if (m_phase == PH_CHK) begin
            m_good++;
            if (m_good == G) m_phase = PH_RUN;
          end
        end else begin
          m_since++;
          if (m_since == T) begin
            if (m_retry < M) begin
              m_retry++;
              m_phase = PH_RST;
              m_left  = R;
            end else begin
              m_phase = PH_FLT;
            end
          end
        end
      end
      default: ;
    endcase
  endtask

  function automatic logic [5:0] model_out();
    logic [3:0] f;
    case (m_phase)
      PH_RST:  f = 4'b1100;
      PH_SET:  f = 4'b0100;
      PH_CHK:  f = 4'b0100;
      PH_RUN:  f = 4'b0010;
      default: f = 4'b1101;
    endcase
    return {f, 2'(m_retry)};
  endfunction

  function automatic logic hb_val(input vec_t v, input int c);
    int cc;
    if (v.period == 0) return 1'b0;
    cc = (c >= v.stop_from && c < v.stop_to) ? v.stop_from : c;
    return 1'((cc / v.period) % 2);
  endfunction

  task automatic apply_reset();
    reset = 1'b1;
    hb_toggle = 1'b0;
    repeat (2) @(negedge refclk);
    check_vec("reset_state", dut_out, 6'b110000);
    model_reset();
    reset = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    logic hbv;
    logic [5:0] exp_o;
    int first_low;
    int lock_seen;
    apply_reset();
    first_low = -1;
    lock_seen = -1;
    for (int c = 1; c <= v.ncyc; c++) begin
      hbv = hb_val(v, c);
      hb_toggle = hbv;
      model_step(hbv);
      sb_q.push_back(model_out());
      @(posedge refclk);
      #1;
      if (sb_q.size() == 0) begin
        check_int($sformatf("%s_sb_empty_c%0d", v.name, c), 0, 1);
      end else begin
        exp_o = sb_q.pop_front();
        check_vec($sformatf("%s_c%0d", v.name, c), dut_out, exp_o);
      end
      if (first_low < 0 && !pll_reset) first_low = c;
      if (lock_seen < 0 && locked) lock_seen = c;
      @(negedge refclk);
    end
    check_vec($sformatf("%s_final", v.name), dut_out, v.final_out);
    check_int($sformatf("%s_pll_reset_width", v.name), first_low - 1, R - 1);
    check_int($sformatf("%s_lock_edge", v.name), lock_seen, v.lock_at);
    // Mid-cycle reset must take effect without a refclk edge
    #2;
    reset = 1'b1;
    #1;
    check_vec($sformatf("%s_async_reset", v.name), dut_out, 6'b110000);
  endtask

  initial begin
    vecs[0] = '{name: "powerup",   period: 4, stop_from: 0,  stop_to: 0,  ncyc: 40,  lock_at: 26, final_out: 6'b001000};
    vecs[1] = '{name: "hb_loss",   period: 4, stop_from: 30, stop_to: 40, ncyc: 100, lock_at: 26, final_out: 6'b001001};
    vecs[2] = '{name: "dead_pll",  period: 0, stop_from: 0,  stop_to: 0,  ncyc: 200, lock_at: -1, final_out: 6'b110110};
    vecs[3] = '{name: "slow_hb",   period: 9, stop_from: 0,  stop_to: 0,  ncyc: 200, lock_at: -1, final_out: 6'b110110};
    vecs[4] = '{name: "edge_at_7", period: 8, stop_from: 0,  stop_to: 0,  ncyc: 80,  lock_at: 34, final_out: 6'b001000};

    for (int i = 0; i < 5; i++) run_vec(vecs[i]);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

endmodule
